sar_adc_reader: RTL and testbench
=================================

SAR_ADC_READER -- requirements
Module: sar_adc_reader

Interface
REQ-001 Parameter WIDTH, default 10: DAC/result width in bits.
REQ-002 Parameter SETTLE_CYCLES, default 10: clk cycles allowed for the DAC and comparator to settle per bit trial; legal range 3..255.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  conversion request, level sampled on clk.
REQ-006 cmp_in  input  1  external comparator, asynchronous: 1 = analog input >= DAC voltage.
REQ-007 dac  output  WIDTH  trial code to the R-2R DAC pins, bit 0 = D0.
REQ-008 busy  output  1  high from start acceptance until done.
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  WIDTH  last completed conversion code.

Function
REQ-011 cmp_in shall pass through a 2-flop synchronizer (cmp_s) before any use; no other path from cmp_in.
REQ-012 FSM states: IDLE, SETTLE, DECIDE, DONE.
REQ-013 IDLE: busy=0, dac holds result; start=1 -> SETTLE, busy=1, bit index k=WIDTH-1, dac = result-independent 1<<(WIDTH-1), settle counter loaded with SETTLE_CYCLES-1.
REQ-014 SETTLE: counter decrements each cycle; at 0 -> DECIDE; SETTLE occupies exactly SETTLE_CYCLES cycles per trial.
REQ-015 DECIDE (1 cycle): if cmp_s=0 clear dac[k], else keep; if k>0 set dac[k-1], k<=k-1, reload counter, -> SETTLE; if k=0 -> DONE.
REQ-016 DONE (1 cycle): result <= dac, done=1, busy=1; next -> IDLE, busy=0.
REQ-017 Latency: done high exactly WIDTH*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start (111 at defaults).
REQ-018 start while SETTLE, DECIDE or DONE shall be ignored, not queued.
REQ-019 start held high continuously: a new conversion begins on the first IDLE cycle after DONE (back-to-back, one idle cycle between done and next busy).
REQ-020 Bits below k in dac shall be 0 during any trial; bits above k hold decided values.
REQ-021 result changes only in DONE; it is stable at all other times.
REQ-022 No arithmetic wrap: k underflow is impossible; counter never decrements below 0.

Reset
REQ-023 rst_n low, any state, asynchronously: state=IDLE, dac=0, result=0, busy=0, done=0, k=WIDTH-1, counter=0, synchronizer flops=0.
REQ-024 Reset mid-conversion shall discard the partial code; result remains 0, no done pulse.
REQ-025 After rst_n rises, first start accepted on the first clk edge with rst_n high.

Verification
REQ-026 Comparator model cmp_in = (VIN >= dac), VIN=700, pulse start 1 cycle -> done after 111 cycles, result=700 (10'b1010111100), trials 512,768,640,704,672,688,696,700,702,701.
REQ-027 VIN=0 -> result=0; VIN=1023 -> result=1023; each with a single done pulse and busy high for 111 cycles.
REQ-028 Pulse start again 20 cycles into a conversion (VIN=300) -> ignored; one done only, result=300.
REQ-029 Hold start high, VIN 300 then 900 switched between conversions -> two conversions, results 300 then 900, done pulses 112 cycles apart.
REQ-030 Assert rst_n low 50 cycles into a conversion (VIN=500) -> dac=0, busy=0, result=0 immediately without clk; new start -> result=500.
REQ-031 Toggle cmp_in asynchronously to clk (random phase) with VIN=511 -> result within {511, 512}, no X on any output.

Source files
------------

// File: rtl/sar_adc_reader.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_reader
// Brief    : Successive-approximation ADC controller driving an R-2R DAC and
//            reading an external asynchronous comparator, MSB first.
// Revision : 1.0  initial release
// ============================================================================
module sar_adc_reader #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int               c_kw          = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_kw-1:0]  c_msb         = c_kw'(WIDTH - 1);
    localparam logic [c_kw-1:0]  c_bit_one     = c_kw'(1);
    localparam logic [7:0]       c_settle_load = 8'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_cmp_sync;
    logic [c_kw-1:0]  r_bit;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_dac;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             w_cmp_s;
    logic [WIDTH-1:0] w_dac_decided;

    // Comparator output is asynchronous; only the second flop is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_sync <= 2'b00;
        end else begin
            r_cmp_sync <= {r_cmp_sync[0], cmp_in};
        end
    end

    assign w_cmp_s       = r_cmp_sync[1];
    assign w_dac_decided = w_cmp_s ? r_dac : (r_dac & ~(c_one << r_bit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SETTLE;
            SETTLE:  if (r_cnt == 8'd0) w_state_next = DECIDE;
            DECIDE:  w_state_next = (r_bit == '0) ? DONE : SETTLE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dac    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_bit    <= c_msb;
            r_cnt    <= 8'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dac <= c_one << c_msb;
                        r_bit <= c_msb;
                        r_cnt <= c_settle_load;
                    end
                end
                SETTLE: begin
                    if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                end
                DECIDE: begin
                    // Resolve bit k, then raise the next lower bit as the new trial.
                    if (r_bit != '0) begin
                        r_dac <= w_dac_decided | (c_one << (r_bit - c_bit_one));
                        r_bit <= r_bit - c_bit_one;
                        r_cnt <= c_settle_load;
                    end else begin
                        r_dac <= w_dac_decided;
                    end
                end
                DONE: begin
                    r_result <= r_dac;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dac    = r_dac;
    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_reader
// Brief    : Self-checking bench for sar_adc_reader with an ideal-comparator
//            analog model and a cycle-level behavioural reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_sar_adc_reader;

    localparam int W     = 10;
    localparam int S     = 10;
    localparam int LAT   = W * (S + 1) + 1;
    localparam int IDLEV = LAT + 1;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         cmp_in = 1'b0;
    logic [W-1:0] dac;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int vin        = 0;
    bit async_mode = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;

    // Reference model state
    int mcyc     = IDLEV;
    int m_trial[W];
    int m_final  = 0;
    int m_result = 0;
    int code_tmp;
    int t_tmp;
    bit start_q  = 1'b0;
    int exp_dac;

    int obs_trial[W];
    int exp_tr[W] = '{512, 768, 640, 704, 672, 688, 696, 700, 702, 701};

    sar_adc_reader #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_in (cmp_in),
        .dac    (dac),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        start_q <= start && rst_n;
    end

    // Ideal comparator; in async mode it reacts after a random delay.
    always begin
        if (async_mode) #($urandom_range(1, 7));
        else #1;
        cmp_in = (vin >= int'(dac));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mcyc     = IDLEV;
            m_result = 0;
        end else if (mcyc < LAT) begin
            mcyc++;
            if (mcyc == LAT) m_result = m_final;
        end else if (start_q) begin
            // Ideal binary search on the captured input value
            code_tmp = 0;
            for (int b = W - 1; b >= 0; b--) begin
                t_tmp = code_tmp | (1 << b);
                m_trial[W-1-b] = t_tmp;
                if (vin >= t_tmp) code_tmp = t_tmp;
            end
            m_final = code_tmp;
            mcyc    = 0;
        end else begin
            mcyc = IDLEV;
        end

        if (mcyc < LAT - 1)  exp_dac = m_trial[mcyc / (S + 1)];
        else if (mcyc < LAT) exp_dac = m_final;
        else                 exp_dac = m_result;

        chk("busy",   busy,   (mcyc < LAT));
        chk("done",   done,   (mcyc == LAT));
        chk("dac",    dac,    exp_dac);
        chk("result", result, m_result);
        if (rst_n) chk("no_x", $isunknown({dac, busy, done, result}), 0);

        if (done === 1'b1) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", (n < 300), 1);
    endtask

    // Called between clock edges; raises start for exactly one sampling edge.
    task automatic pulse_and_wait(input int v, output int lat, output int busy_n);
        int n;
        vin   = v;
        start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        n      = 0;
        busy_n = 0;
        while (done !== 1'b1 && n < 300) begin
            if (busy === 1'b1) busy_n++;
            if ((n % (S + 1)) == 5 && (n / (S + 1)) < W) obs_trial[n / (S + 1)] = int'(dac);
            @(posedge clk); #1;
            n++;
        end
        lat = n;
        chk("done_timeout", (n < 300), 1);
    endtask

    int lat, bn, n, d0;

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_dac",    dac,    0);
        chk("rst_result", result, 0);

        // Mid-scale reference conversion with known trial sequence
        d0 = done_cnt;
        pulse_and_wait(700, lat, bn);
        chk("lat_700",  lat,    111);
        chk("busy_700", bn,     111);
        chk("res_700",  result, 700);
        for (int i = 0; i < W; i++) begin
            chk("trial_700",       obs_trial[i], exp_tr[i]);
            chk("model_trial_700", m_trial[i],   exp_tr[i]);
        end
        repeat (5) @(posedge clk); #1;
        chk("pulses_700", done_cnt - d0, 1);

        // Range extremes
        d0 = done_cnt;
        pulse_and_wait(0, lat, bn);
        chk("lat_0",  lat,    111);
        chk("busy_0", bn,     111);
        chk("res_0",  result, 0);
        repeat (5) @(posedge clk); #1;
        chk("pulses_0", done_cnt - d0, 1);
        chk("idle_busy_0", busy, 0);

        d0 = done_cnt;
        pulse_and_wait(1023, lat, bn);
        chk("lat_1023",  lat,    111);
        chk("busy_1023", bn,     111);
        chk("res_1023",  result, 1023);
        repeat (5) @(posedge clk); #1;
        chk("pulses_1023", done_cnt - d0, 1);

        // Second start during a conversion is dropped
        d0    = done_cnt;
        vin   = 300;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(n);
        chk("res_ignore", result, 300);
        repeat (130) @(posedge clk); #1;
        chk("pulses_ignore", done_cnt - d0, 1);

        // Start held high: back-to-back conversions
        d0    = done_cnt;
        vin   = 300;
        start = 1'b1;
        wait_done(n);
        chk("res_b2b_1", result, 300);
        vin = 900;
        @(posedge clk); #1;
        wait_done(n);
        chk("res_b2b_2", result, 900);
        start = 1'b0;
        repeat (5) @(posedge clk); #1;
        chk("pulses_b2b",  done_cnt - d0, 2);
        chk("spacing_b2b", last_done_cyc - prev_done_cyc, 112);

        // Asynchronous reset mid-conversion
        vin   = 500;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dac",    dac,    0);
        chk("arst_busy",   busy,   0);
        chk("arst_result", result, 0);
        chk("arst_done",   done,   0);
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        pulse_and_wait(500, lat, bn);
        chk("lat_after_rst", lat,    111);
        chk("res_after_rst", result, 500);
        repeat (5) @(posedge clk); #1;
        chk("pulses_after_rst", done_cnt - d0, 1);

        // Comparator changing at random phase relative to clk
        async_mode = 1'b1;
        pulse_and_wait(511, lat, bn);
        chk("res_async_set", (result == 10'd511 || result == 10'd512), 1);
        chk("lat_async", lat, 111);
        async_mode = 1'b0;

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
